// File: rtl/gpac_dac_tx_core.sv
// gpac_dac_tx_core: 256 x 14-bit pattern memory loaded over the basil bus and
// replayed to a DAC channel at a divided rate (one-shot, N loops or endless).
module gpac_dac_tx_core #(
  parameter int unsigned ABUSWIDTH = 16,
  parameter logic [1:0]  DAC_ID    = 2'd0
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 BUS_WR,
  input  logic                 BUS_RD,
  input  logic                 DAC_TRIGGER,
  output logic [13:0]          DAC_DATA,
  output logic                 DAC_STB,
  output logic                 DAC_SYNC,
  output logic                 BUSY
);

  localparam logic [5:0]           VERSION   = 6'd1;
  localparam logic [ABUSWIDTH-1:0] REG_COUNT = ABUSWIDTH'(12);

  localparam logic [3:0] A_ID      = 4'd0;
  localparam logic [3:0] A_CMD     = 4'd1;
  localparam logic [3:0] A_CONF    = 4'd2;
  localparam logic [3:0] A_LEN     = 4'd3;
  localparam logic [3:0] A_REPEAT  = 4'd4;
  localparam logic [3:0] A_DIV     = 4'd5;
  localparam logic [3:0] A_IDLE_LO = 4'd6;
  localparam logic [3:0] A_IDLE_HI = 4'd7;
  localparam logic [3:0] A_PTR     = 4'd8;
  localparam logic [3:0] A_STAGE   = 4'd9;
  localparam logic [3:0] A_COMMIT  = 4'd10;
  localparam logic [3:0] A_LOOPS   = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PLAY} state_e;

  // Reset asserts asynchronously but is released two clock edges later.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) rst_sync <= '0;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [3:0] reg_sel;
  logic       reg_hit, wr_hit, soft_rst, start_wr, commit;

  assign reg_sel  = BUS_ADD[3:0];
  assign reg_hit  = (BUS_ADD < REG_COUNT);
  assign wr_hit   = BUS_WR && reg_hit;
  assign soft_rst = wr_hit && (reg_sel == A_ID);
  assign start_wr = wr_hit && (reg_sel == A_CMD);
  assign commit   = wr_hit && (reg_sel == A_COMMIT);

  logic [1:0]  conf_q;
  logic [7:0]  len_q, rpt_q, div_q, ptr_q, staging_q;
  logic [13:0] idle_q;

  always_ff @(posedge BUS_CLK or negedge rst_n) begin
    if (!rst_n) begin
      conf_q    <= '0;
      len_q     <= '0;
      rpt_q     <= '0;
      div_q     <= '0;
      idle_q    <= '0;
      ptr_q     <= '0;
      staging_q <= '0;
    end else if (soft_rst) begin
      conf_q    <= '0;
      len_q     <= '0;
      rpt_q     <= '0;
      div_q     <= '0;
      idle_q    <= '0;
      ptr_q     <= '0;
      staging_q <= '0;
    end else if (wr_hit) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      case (reg_sel)
        A_CONF:    conf_q         <= BUS_DATA_IN[1:0];
        A_LEN:     len_q          <= BUS_DATA_IN;
        A_REPEAT:  rpt_q          <= BUS_DATA_IN;
        A_DIV:     div_q          <= BUS_DATA_IN;
        A_IDLE_LO: idle_q[7:0]    <= BUS_DATA_IN;
        A_IDLE_HI: idle_q[13:8]   <= BUS_DATA_IN[5:0];
        A_PTR:     ptr_q          <= BUS_DATA_IN;
        A_STAGE:   staging_q      <= BUS_DATA_IN;
        A_COMMIT:  ptr_q          <= ptr_q + 8'd1;
        default: ;
      endcase
    end
  end

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d, tick_q, tick_d, loop_q, loop_d, len_m1;
  logic        done_q, done_d, start_q, trig_q, trig_prev, end_q;
  logic        sample_tick, end_tick;
  logic [13:0] mem_q;

  // LEN==0 wraps to 255 here, which is exactly the 256-sample pattern.
  assign len_m1 = len_q - 8'd1;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d     = state_q;
    idx_d       = idx_q;
    tick_d      = tick_q;
    loop_d      = loop_q;
    done_d      = done_q;
    sample_tick = 1'b0;
    end_tick    = 1'b0;
    if (soft_rst) begin
      state_d = S_IDLE;
      idx_d   = '0;
      tick_d  = '0;
      loop_d  = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_q) begin
            state_d = conf_q[0] ? S_ARMED : S_PLAY;
            idx_d   = '0;
            tick_d  = '0;
            loop_d  = '0;
            done_d  = 1'b0;
          end
        end
        S_ARMED: begin
          if (trig_q && !trig_prev) state_d = S_PLAY;
        end
        S_PLAY: begin
          tick_d = (tick_q == div_q) ? 8'd0 : tick_q + 8'd1;
          if (tick_q == 8'd0) begin
            if ((rpt_q != 8'd0) && (loop_q == rpt_q)) begin
              end_tick = 1'b1;
              done_d   = 1'b1;
              state_d  = S_IDLE;
              idx_d    = '0;
              tick_d   = '0;
            end else begin
              sample_tick = 1'b1;
              if (idx_q == len_m1) begin
                idx_d = '0;
                if (loop_q != 8'hFF) loop_d = loop_q + 8'd1;
              end else begin
                idx_d = idx_q + 8'd1;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Read address is the index the next strobe will use, so mem_q is ready in time.
  logic [13:0] mem [256];

  always_ff @(posedge BUS_CLK) begin
    // NOTE: pattern memory has no reset; it must survive soft reset and maps onto block RAM.
    if (commit) mem[ptr_q] <= {BUS_DATA_IN[5:0], staging_q};
    mem_q <= mem[idx_d];
  end

  logic [7:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (reg_hit) begin
      case (reg_sel)
        A_ID:      rd_data = {DAC_ID, VERSION};
        A_CMD:     rd_data = {6'b0, BUSY, done_q};
        A_CONF:    rd_data = {6'b0, conf_q};
        A_LEN:     rd_data = len_q;
        A_REPEAT:  rd_data = rpt_q;
        A_DIV:     rd_data = div_q;
        A_IDLE_LO: rd_data = idle_q[7:0];
        A_IDLE_HI: rd_data = {2'b0, idle_q[13:8]};
        A_PTR:     rd_data = ptr_q;
        A_STAGE:   rd_data = staging_q;
        A_COMMIT:  rd_data = ptr_q;
        A_LOOPS:   rd_data = loop_q;
        default:   rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      tick_q       <= '0;
      loop_q       <= '0;
      done_q       <= 1'b0;
      start_q      <= 1'b0;
      trig_q       <= 1'b0;
      trig_prev    <= 1'b0;
      end_q        <= 1'b0;
      DAC_DATA     <= '0;
      DAC_STB      <= 1'b0;
      DAC_SYNC     <= 1'b0;
      BUS_DATA_OUT <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tick_q    <= tick_d;
      loop_q    <= loop_d;
      done_q    <= done_d;
      start_q   <= start_wr;
      trig_q    <= DAC_TRIGGER;
      trig_prev <= trig_q;
      end_q     <= end_tick;
      DAC_STB   <= sample_tick || end_tick;
      DAC_SYNC  <= sample_tick && (idx_q == 8'd0);
      if (soft_rst)                     DAC_DATA <= '0;
      else if (sample_tick)             DAC_DATA <= mem_q;
      else if (end_tick && !conf_q[1])  DAC_DATA <= idle_q;
      if (BUS_RD) BUS_DATA_OUT <= rd_data;
    end
  end

  // BUSY is held for the cycle of the end strobe and drops on the following edge.
  assign BUSY = (state_q != S_IDLE) || end_q;

endmodule

// File: tb/tb_gpac_dac_tx_core.sv
// Bench for gpac_dac_tx_core: expected strobes (data, sync, cycle) are queued
// when a run is started and popped by a negedge monitor as DAC_STB appears.
`timescale 1ns/1ps
module tb_gpac_dac_tx_core;

  localparam int         AW         = 16;
  localparam logic [7:0] VERSION_RD = 8'h81;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [AW-1:0] bus_add  = '0;
  logic [7:0]    bus_din  = '0;
  logic          bus_wr   = 1'b0;
  logic          bus_rd   = 1'b0;
  logic          trig     = 1'b0;
  logic [7:0]    bus_dout;
  logic [13:0]   dac_data;
  logic          dac_stb, dac_sync, busy;

  gpac_dac_tx_core #(.ABUSWIDTH(AW), .DAC_ID(2'd2)) dut (
    .BUS_CLK      (clk),
    .BUS_RST_N    (rst_n),
    .BUS_ADD      (bus_add),
    .BUS_DATA_IN  (bus_din),
    .BUS_DATA_OUT (bus_dout),
    .BUS_WR       (bus_wr),
    .BUS_RD       (bus_rd),
    .DAC_TRIGGER  (trig),
    .DAC_DATA     (dac_data),
    .DAC_STB      (dac_stb),
    .DAC_SYNC     (dac_sync),
    .BUSY         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] data;
    logic        sync;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [13:0] model_mem [256];
  int unsigned model_ptr = 0;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (dac_stb !== 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe cyc=%0d data=%h sync=%b, required no strobe", cyc, dac_data, dac_sync);
      end else begin
        mon_e = sb.pop_front();
        if (dac_stb !== 1'b1 || dac_data !== mon_e.data || dac_sync !== mon_e.sync || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL strobe got data=%h sync=%b cyc=%0d, required data=%h sync=%b cyc=%0d",
                   dac_data, dac_sync, cyc, mon_e.data, mon_e.sync, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d, required completion", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic push_exp(input logic [13:0] d, input logic s, input int unsigned c);
    exp_t e;
    e.data = d;
    e.sync = s;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Bus tasks are entered and left just after a falling edge.
  task automatic bus_write(input logic [AW-1:0] a, input logic [7:0] d);
    bus_add = a;
    bus_din = d;
    bus_wr  = 1'b1;
    @(negedge clk);
    bus_wr  = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [7:0] d);
    bus_add = a;
    bus_rd  = 1'b1;
    @(negedge clk);
    bus_rd  = 1'b0;
    d       = bus_dout;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic load_word(input logic [13:0] v);
    bus_write(AW'(9), v[7:0]);
    bus_write(AW'(10), {2'b00, v[13:8]});
    model_mem[model_ptr[7:0]] = v;
    model_ptr = (model_ptr + 1) % 256;
  endtask

  task automatic program_run(input logic [7:0] conf, input logic [7:0] len,
                             input logic [7:0] rpt, input logic [7:0] div);
    bus_write(AW'(2), conf);
    bus_write(AW'(3), len);
    bus_write(AW'(4), rpt);
    bus_write(AW'(5), div);
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    logic [7:0] exp_rd;
    checks++;
    if (dac_data !== 14'd0 || dac_stb !== 1'b0 || dac_sync !== 1'b0 || busy !== 1'b0 || bus_dout !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs data=%h stb=%b sync=%b busy=%b dout=%h, required all 0",
               dac_data, dac_stb, dac_sync, busy, bus_dout);
    end
    for (int a = 0; a < 14; a++) begin
      exp_rd = (a == 0) ? VERSION_RD : 8'h00;
      bus_read(AW'(a), rd);
      checks++;
      if (rd !== exp_rd) begin
        errors++;
        $display("FAIL reset_reg%0d got=%h, required=%h", a, rd, exp_rd);
      end
    end
  endtask

  task automatic test_oneshot();
    int unsigned n;
    logic [7:0]  rd;
    bus_write(AW'(8), 8'd0);
    model_ptr = 0;
    load_word(14'h0001);
    load_word(14'h3FFF);
    load_word(14'h2000);
    load_word(14'h0000);
    bus_write(AW'(6), 8'h34);
    bus_write(AW'(7), 8'h12);
    program_run(8'd0, 8'd4, 8'd1, 8'd0);
    bus_write(AW'(1), 8'd0);
    n = cyc;
    for (int k = 0; k < 4; k++) push_exp(model_mem[k], k == 0, n + 2 + k);
    push_exp(14'h1234, 1'b0, n + 6);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_busy_start got=%b, required 1", busy);
    end
    wait_until(n + 7);
    drain_check("oneshot");
    checks++;
    if (busy !== 1'b0 || dac_data !== 14'h1234) begin
      errors++;
      $display("FAIL oneshot_after busy=%b data=%h, required busy=0 data=1234", busy, dac_data);
    end
    bus_read(AW'(1), rd);
    checks++;
    if (rd !== 8'h01) begin
      errors++;
      $display("FAIL oneshot_status got=%h, required 01", rd);
    end
    bus_read(AW'(11), rd);
    checks++;
    if (rd !== 8'd1) begin
      errors++;
      $display("FAIL oneshot_loops got=%0d, required 1", rd);
    end
  endtask

  task automatic test_div_hold();
    int unsigned n;
    logic [7:0]  rd;
    program_run(8'h02, 8'd2, 8'd3, 8'd3);
    bus_write(AW'(1), 8'd0);
    n = cyc;
    for (int k = 0; k < 6; k++) push_exp(model_mem[k % 2], (k % 2) == 0, n + 2 + 4 * k);
    push_exp(model_mem[1], 1'b0, n + 26);
    wait_until(n + 27);
    drain_check("div_hold");
    bus_read(AW'(11), rd);
    checks++;
    if (rd !== 8'd3) begin
      errors++;
      $display("FAIL div_hold_loops got=%0d, required 3", rd);
    end
    bus_read(AW'(1), rd);
    checks++;
    if (rd !== 8'h01) begin
      errors++;
      $display("FAIL div_hold_status got=%h, required 01", rd);
    end
  endtask

  task automatic test_trigger();
    int unsigned n;
    int unsigned t;
    trig = 1'b1;
    program_run(8'h01, 8'd4, 8'd1, 8'd0);
    bus_write(AW'(1), 8'd0);
    n = cyc;
    wait_until(n + 6);
    checks++;
    if (busy !== 1'b1 || dac_stb !== 1'b0) begin
      errors++;
      $display("FAIL trigger_armed busy=%b stb=%b, required busy=1 stb=0", busy, dac_stb);
    end
    trig = 1'b0;
    repeat (3) @(negedge clk);
    trig = 1'b1;
    t = cyc + 1;
    for (int k = 0; k < 4; k++) push_exp(model_mem[k], k == 0, t + 2 + k);
    push_exp(14'h1234, 1'b0, t + 6);
    wait_until(t + 7);
    trig = 1'b0;
    drain_check("trigger");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL trigger_end busy=%b, required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned n;
    logic [7:0]  rd;
    program_run(8'd0, 8'd4, 8'd1, 8'd1);
    bus_write(AW'(1), 8'd0);
    n = cyc;
    for (int k = 0; k < 4; k++) push_exp(model_mem[k], k == 0, n + 2 + 2 * k);
    push_exp(14'h1234, 1'b0, n + 10);
    wait_until(n + 2);
    bus_write(AW'(1), 8'd0);
    wait_until(n + 11);
    drain_check("second_start");
    bus_read(AW'(1), rd);
    checks++;
    if (rd !== 8'h01) begin
      errors++;
      $display("FAIL second_start_status got=%h, required 01", rd);
    end

    program_run(8'd0, 8'd4, 8'd0, 8'd0);
    bus_write(AW'(1), 8'd0);
    n = cyc;
    push_exp(model_mem[0], 1'b1, n + 2);
    push_exp(model_mem[1], 1'b0, n + 3);
    wait_until(n + 3);
    bus_write(AW'(0), 8'd0);
    checks++;
    if (dac_data !== 14'd0 || dac_stb !== 1'b0) begin
      errors++;
      $display("FAIL soft_reset_out data=%h stb=%b, required data=0 stb=0", dac_data, dac_stb);
    end
    wait_until(n + 14);
    drain_check("soft_reset");
    bus_read(AW'(1), rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL soft_reset_status got=%h, required 00", rd);
    end
    bus_read(AW'(3), rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL soft_reset_len got=%h, required 00", rd);
    end

    program_run(8'd0, 8'd2, 8'd1, 8'd0);
    bus_write(AW'(1), 8'd0);
    n = cyc;
    push_exp(model_mem[0], 1'b1, n + 2);
    push_exp(model_mem[1], 1'b0, n + 3);
    push_exp(14'd0, 1'b0, n + 4);
    wait_until(n + 5);
    drain_check("rerun");
  endtask

  task automatic test_endless();
    int unsigned n;
    logic [7:0]  rd;
    logic [15:0] v;
    bus_write(AW'(8), 8'd0);
    model_ptr = 0;
    for (int i = 0; i < 256; i++) begin
      v = (16'(i) * 16'h0A5B) ^ 16'h1234;
      load_word(v[13:0]);
    end
    program_run(8'd0, 8'd0, 8'd0, 8'd0);
    bus_write(AW'(1), 8'd0);
    n = cyc;
    for (int k = 0; k < 520; k++) push_exp(model_mem[k % 256], (k % 256) == 0, n + 2 + k);
    wait_until(n + 520);
    bus_read(AW'(11), rd);
    checks++;
    if (rd !== 8'd2) begin
      errors++;
      $display("FAIL endless_loops got=%0d, required 2", rd);
    end
    bus_write(AW'(0), 8'd0);
    wait_until(n + 530);
    drain_check("endless");

    bus_write(AW'(3), 8'd1);
    bus_write(AW'(1), 8'd0);
    n = cyc;
    for (int k = 0; k < 301; k++) push_exp(model_mem[0], 1'b1, n + 2 + k);
    wait_until(n + 300);
    bus_read(AW'(11), rd);
    checks++;
    if (rd !== 8'd255) begin
      errors++;
      $display("FAIL loops_saturate got=%0d, required 255", rd);
    end
    bus_read(AW'(1), rd);
    checks++;
    if (rd !== 8'h02) begin
      errors++;
      $display("FAIL endless_status got=%h, required 02", rd);
    end
    bus_write(AW'(0), 8'd0);
    wait_until(n + 310);
    drain_check("saturate");
  endtask

  task automatic test_async_reset();
    int unsigned n;
    program_run(8'd0, 8'd0, 8'd0, 8'd0);
    bus_write(AW'(1), 8'd0);
    n = cyc;
    for (int k = 0; k < 4; k++) push_exp(model_mem[k], k == 0, n + 2 + k);
    wait_until(n + 5);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dac_data !== 14'd0 || dac_stb !== 1'b0 || dac_sync !== 1'b0 || busy !== 1'b0 || bus_dout !== 8'd0) begin
      errors++;
      $display("FAIL async_reset_out data=%h stb=%b sync=%b busy=%b dout=%h, required all 0",
               dac_data, dac_stb, dac_sync, busy, bus_dout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    drain_check("async_reset");
    test_reset();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_oneshot();
    test_div_hold();
    test_trigger();
    test_back_to_back();
    test_endless();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
